// File: rtl/sync_fifo_mon_if.sv
// sync_fifo_mon_if: data handshake bundle for sync_fifo_mon.
// master drives wdata/winc/rinc; slave returns rdata/wfull/rempty.
interface sync_fifo_mon_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] wdata;
  logic                  winc;
  logic                  wfull;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rempty;

  modport master (
    output wdata, winc, rinc,
    input  rdata, wfull, rempty
  );

  modport slave (
    input  wdata, winc, rinc,
    output rdata, wfull, rempty
  );
endinterface

// File: rtl/sync_fifo_mon.sv
// sync_fifo_mon: single-clock FIFO with occupancy, thresholds,
// sticky over/underflow flags and a high-watermark tracker.
// Ports: clk, rst_n (async low); fif (wdata/winc/rinc/rdata/
// wfull/rempty); almost_full/almost_empty, count, overflow,
// underflow, err_clr, wm_clr, watermark.
module sync_fifo_mon #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sync_fifo_mon_if.slave        fif,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr,
  input  logic                  wm_clr,
  output logic [ADDR_WIDTH:0]   watermark
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wbin;
  logic [PW-1:0]         rbin;
  logic [PW-1:0]         nxt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  full;
  logic                  empty;
  logic                  wr_ok;
  logic                  rd_ok;

  // Extra pointer bit makes the modular difference span 0..DEPTH.
  assign count = wbin - rbin;
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);

  assign almost_full  = (count >= PW'(AFULL_THRESH));
  assign almost_empty = (count <= PW'(AEMPTY_THRESH));

  assign wr_ok = fif.winc && !full;
  assign rd_ok = fif.rinc && !empty;

  assign fif.wfull  = full;
  assign fif.rempty = empty;
  assign fif.rdata  = rdata_q;

  always_comb begin
    nxt = count;
    unique case (1'b1)
      wr_ok && !rd_ok: nxt = count + PW'(1);
      rd_ok && !wr_ok: nxt = count - PW'(1);
      default:         nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wbin[ADDR_WIDTH-1:0]] <= fif.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin      <= '0;
      rbin      <= '0;
      rdata_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      watermark <= '0;
    end else begin
      if (wr_ok)
        wbin <= wbin + PW'(1);
      if (rd_ok) begin
        rbin    <= rbin + PW'(1);
        rdata_q <= mem[rbin[ADDR_WIDTH-1:0]];
      end
      // A fresh error outranks a clear in the same cycle.
      if (fif.winc && full)
        overflow <= 1'b1;
      else if (err_clr)
        overflow <= 1'b0;
      if (fif.rinc && empty)
        underflow <= 1'b1;
      else if (err_clr)
        underflow <= 1'b0;
      // Clearing restarts tracking from the post-edge occupancy.
      if (wm_clr)
        watermark <= nxt;
      else if (nxt > watermark)
        watermark <= nxt;
    end
  end

endmodule

// File: tb/tb_sync_fifo_mon.sv
// tb_sync_fifo_mon: directed and random checks of sync_fifo_mon
// against a queue-based reference model.
module tb_sync_fifo_mon;

  logic       clk;
  logic       rst_n;
  logic       err_clr;
  logic       wm_clr;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic [4:0] watermark;

  int n_cmp;
  int n_bad;

  logic [7:0] q[$];
  logic [7:0] m_rd;
  bit         m_ovf;
  bit         m_unf;
  int         m_wm;

  sync_fifo_mon_if #(.DATA_WIDTH(8)) bus ();

  sync_fifo_mon #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .AFULL_THRESH(12),
    .AEMPTY_THRESH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fif(bus),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow),
    .err_clr(err_clr),
    .wm_clr(wm_clr),
    .watermark(watermark)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".rdata"}, 32'(bus.rdata), 32'(m_rd));
    chk({tag, ".wfull"}, 32'(bus.wfull), 32'(n == 16));
    chk({tag, ".rempty"}, 32'(bus.rempty), 32'(n == 0));
    chk({tag, ".afull"}, 32'(almost_full), 32'(n >= 12));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= 2));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    chk({tag, ".wm"}, 32'(watermark), 32'(m_wm));
  endtask

  task automatic model_reset();
    q.delete();
    m_rd  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_wm  = 0;
  endtask

  task automatic step(string tag, bit w, logic [7:0] wd, bit r,
                      bit ec = 1'b0, bit wc = 1'b0);
    bit full;
    bit empty;
    int n;
    bus.winc  = w;
    bus.wdata = wd;
    bus.rinc  = r;
    err_clr   = ec;
    wm_clr    = wc;
    @(posedge clk);
    full  = (q.size() == 16);
    empty = (q.size() == 0);
    if (w && full) m_ovf = 1'b1;
    else if (ec) m_ovf = 1'b0;
    if (r && empty) m_unf = 1'b1;
    else if (ec) m_unf = 1'b0;
    if (r && !empty) m_rd = q.pop_front();
    if (w && !full) q.push_back(wd);
    n = q.size();
    if (wc) m_wm = n;
    else if (n > m_wm) m_wm = n;
    #1;
    check_all(tag);
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    err_clr  = 1'b0;
    wm_clr   = 1'b0;
  endtask

  // Called just after an edge; asserts reset between edges.
  task automatic async_reset(string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(posedge clk);
    #1;
    check_all({tag, ".hold"});
    #2 rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.winc  = 1'b0;
    bus.rinc  = 1'b0;
    bus.wdata = '0;
    err_clr   = 1'b0;
    wm_clr    = 1'b0;
    rst_n     = 1'b1;
    model_reset();

    // Reset between edges.
    #2 rst_n = 1'b0;
    #1;
    chk("rst.rempty", 32'(bus.rempty), 32'd1);
    chk("rst.aempty", 32'(almost_empty), 32'd1);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.rdata", 32'(bus.rdata), 32'h00);
    @(posedge clk);
    #1;
    check_all("rst");
    #2 rst_n = 1'b1;

    // Fill.
    for (int i = 0; i < 16; i++) begin
      step("fill", 1'b1, 8'(i), 1'b0);
      if (i == 1) chk("fill.ae2", 32'(almost_empty), 32'd1);
      if (i == 2) chk("fill.ae3", 32'(almost_empty), 32'd0);
      if (i == 10) chk("fill.af11", 32'(almost_full), 32'd0);
      if (i == 11) chk("fill.af12", 32'(almost_full), 32'd1);
    end
    chk("fill.wfull", 32'(bus.wfull), 32'd1);
    chk("fill.cnt16", 32'(count), 32'd16);
    step("ovf", 1'b1, 8'hAA, 1'b0);
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.cnt", 32'(count), 32'd16);
    chk("ovf.wm", 32'(watermark), 32'd16);

    // Drain.
    for (int i = 0; i < 16; i++) begin
      step("drain", 1'b0, 8'h00, 1'b1);
      chk("drain.data", 32'(bus.rdata), 32'(i));
    end
    chk("drain.empty", 32'(bus.rempty), 32'd1);
    step("unf", 1'b0, 8'h00, 1'b1);
    chk("unf.flag", 32'(underflow), 32'd1);
    chk("unf.hold", 32'(bus.rdata), 32'h0F);

    // Wrap: clear history, then stream 40 words at count 1..5.
    step("wclr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)
      step("wrap.pre", 1'b1, 8'(i), 1'b0);
    for (int i = 5; i < 40; i++) begin
      step("wrap", 1'b1, 8'(i), 1'b1);
      chk("wrap.data", 32'(bus.rdata), 32'(i - 5));
    end
    for (int i = 35; i < 40; i++) begin
      step("wrap.post", 1'b0, 8'h00, 1'b1);
      chk("wrap.data", 32'(bus.rdata), 32'(i));
    end
    chk("wrap.wm", 32'(watermark), 32'd5);
    chk("wrap.ovf", 32'(overflow), 32'd0);
    chk("wrap.unf", 32'(underflow), 32'd0);

    // Simultaneous at boundaries.
    for (int i = 0; i < 16; i++)
      step("b.fill", 1'b1, 8'($urandom), 1'b0);
    step("b.full", 1'b1, 8'h11, 1'b1);
    chk("b.full.cnt", 32'(count), 32'd15);
    chk("b.full.ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 15; i++)
      step("b.drain", 1'b0, 8'h00, 1'b1);
    step("b.empty", 1'b1, 8'h22, 1'b1);
    chk("b.empty.cnt", 32'(count), 32'd1);
    chk("b.empty.unf", 32'(underflow), 32'd1);
    step("b.clr", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("b.clr.ovf", 32'(overflow), 32'd0);
    chk("b.clr.unf", 32'(underflow), 32'd0);
    for (int i = 0; i < 15; i++)
      step("b.refill", 1'b1, 8'($urandom), 1'b0);
    step("b.setwin", 1'b1, 8'h33, 1'b0, 1'b1);
    chk("b.setwin.ovf", 32'(overflow), 32'd1);

    // Reset mid-operation.
    for (int i = 0; i < 16; i++)
      step("m.drain", 1'b0, 8'h00, 1'b1);
    step("m.clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++)
      step("m.fill", 1'b1, 8'(8'h40 + i), 1'b0);
    chk("m.cnt7", 32'(count), 32'd7);
    chk("m.wm7", 32'(watermark), 32'd7);
    async_reset("m.rst");
    chk("m.rst.cnt", 32'(count), 32'd0);
    chk("m.rst.wm", 32'(watermark), 32'd0);
    step("m.w", 1'b1, 8'h5A, 1'b0);
    step("m.r", 1'b0, 8'h00, 1'b1);
    chk("m.r.data", 32'(bus.rdata), 32'h5A);

    // Random traffic with shifting write bias.
    for (int p = 0; p < 6; p++) begin
      int pw;
      pw = (p % 2 == 0) ? 75 : 25;
      for (int i = 0; i < 120; i++) begin
        step("rnd",
             $urandom_range(99) < pw,
             8'($urandom),
             $urandom_range(99) < (100 - pw),
             $urandom_range(99) < 5,
             $urandom_range(99) < 5);
      end
    end
    async_reset("rnd.rst");
    for (int i = 0; i < 60; i++)
      step("rnd2", 1'($urandom), 8'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
